calc_seq: RTL and testbench

//  Token-driven sequencer in front of the 4-bit add/sub/mul units. Accepts a serial

---
 rtl/calc_pkg.sv | 7 +
 rtl/calc_exec.sv | 45 ++++
 rtl/calc_seq.sv | 98 +++++++++
 tb/tb_calc_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared width, token-kind, opcode and state types for the calculator sequencer
package calc_pkg;
    localparam int DW = 4;
    typedef enum logic [1:0] {TK_DIGIT, TK_OP, TK_EQ, TK_CLR} token_kind_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_RSVD} opcode_e;
    typedef enum logic [2:0] {S_A, S_OP, S_B, S_EQ, S_EXEC, S_OUT} state_e;
endpackage

// File: rtl/calc_exec.sv
// calc_exec: 4-bit add/sub/mul units and the opcode-selected 8-bit result mux
module cal_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] s
);
    assign s = {1'b0, a} + {1'b0, b};
endmodule

module cal_sub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] d
);
    assign d = {1'b0, a} - {1'b0, b};
endmodule

module cal_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'b0, a} * {4'b0, b};
endmodule

module calc_exec
    import calc_pkg::*;
(
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  opcode_e         op,
    output logic [2*DW-1:0] res
);
    logic [DW:0] sum, diff;
    logic [2*DW-1:0] prod;
    cal_add u_add (.a(a), .b(b), .s(sum));
    cal_sub u_sub (.a(a), .b(b), .d(diff));
    cal_mul u_mul (.a(a), .b(b), .p(prod));
    // reserved opcode is never dispatched, so it simply yields zero
    always_comb begin
        res = op == OP_ADD ? {{(DW-1){1'b0}}, sum} :
              op == OP_SUB ? {{(DW-1){1'b0}}, diff} :
              op == OP_MUL ? prod : '0;
    end
endmodule

// File: rtl/calc_seq.sv
// calc_seq: token sequencer capturing A/op/B, dispatching to calc_exec, holding the result (CALC_CHAIN_EN enables running totals)
module calc_seq
    import calc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_kind,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_res,
    output logic [1:0]      out_op,
    output logic            err,
    output logic            busy
);
    state_e state, nxt;
    token_kind_e kind;
    opcode_e op, opc;
    logic [DW-1:0] a, b;
    logic [2*DW-1:0] res;
    logic tok, chain_go, ld_a, ld_chain, ld_op, ld_b, go_eq, clr, err_n, zero, fire, done;

    assign kind = token_kind_e'(in_kind);
    assign opc = opcode_e'(in_data[1:0]);
    assign in_ready = state != S_EXEC && state != S_OUT;
    assign busy = !in_ready;
    assign tok = in_valid && in_ready;

`ifdef CALC_CHAIN_EN
    logic chain_ok;
    // armed by a delivered result, dropped by anything that starts a fresh expression
    always_ff @(posedge clk) begin
        if (rst) chain_ok <= 1'b0;
        else chain_ok <= done || (chain_ok && !zero && !ld_a);
    end
    assign chain_go = chain_ok;
`else
    assign chain_go = 1'b0;
`endif

    // classify the accepted token, derive load strobes and the next state
    always_comb begin
        ld_a = tok && state == S_A && kind == TK_DIGIT;
        ld_chain = tok && state == S_A && kind == TK_OP && chain_go && opc != OP_RSVD;
        ld_op = ld_chain || (tok && state == S_OP && kind == TK_OP && opc != OP_RSVD);
        ld_b = tok && state == S_B && kind == TK_DIGIT;
        go_eq = tok && state == S_EQ && kind == TK_EQ;
        clr = tok && kind == TK_CLR;
        err_n = tok && !(ld_a || ld_op || ld_b || go_eq || clr);
        zero = clr || err_n;
        fire = state == S_EXEC;
        done = state == S_OUT && out_ready;
        nxt = zero ? S_A : ld_a ? S_OP : ld_op ? S_B : ld_b ? S_EQ : go_eq ? S_EXEC :
              fire ? S_OUT : done ? S_A : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_A;
        else state <= nxt;
    end

    calc_exec u_exec (.a(a), .b(b), .op(op), .res(res));

    // operand capture, result register and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            op <= OP_ADD;
            out_res <= '0;
            out_op <= '0;
            out_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            err <= err_n;
            if (zero) begin
                a <= '0;
                b <= '0;
                op <= OP_ADD;
            end else begin
                if (ld_a) a <= in_data;
                if (ld_chain) a <= out_res[DW-1:0];
                if (ld_op) op <= opc;
                if (ld_b) b <= in_data;
            end
            if (fire) begin
                out_res <= res;
                out_op <= op;
                out_valid <= 1'b1;
            end else if (done) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed and randomized token streams checked against an expression-level model
module tb_calc_seq;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, err, busy;
    logic [1:0] in_kind, out_op;
    logic [3:0] in_data;
    logic [7:0] out_res;
    int nvec = 0, nbad = 0;
    int expr[$];
    bit computing, holding, m_err, chain;
    int m_res, m_op;

`ifdef CALC_CHAIN_EN
    localparam bit CH = 1'b1;
`else
    localparam bit CH = 1'b0;
`endif

    always #5 clk = ~clk;

    calc_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_op(out_op),
        .err(err), .busy(busy)
    );

    function automatic int calc(input int x, input int o, input int y);
        return o == 0 ? x + y : o == 1 ? (x - y) & 31 : o == 2 ? x * y : 0;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit v, input int k, input int d, input bit ordy);
        if (r) begin
            expr.delete();
            computing = 0; holding = 0; m_err = 0; chain = 0; m_res = 0; m_op = 0;
        end else begin
            m_err = 0;
            if (computing) begin
                m_res = calc(expr[0], expr[1], expr[2]);
                m_op = expr[1];
                expr.delete();
                computing = 0;
                holding = 1;
            end else if (holding) begin
                if (ordy) begin holding = 0; chain = 1; end
            end else if (v) begin
                if (k == 3) begin expr.delete(); chain = 0; end
                else if (k == 0 && expr.size() == 0) begin expr.push_back(d); chain = 0; end
                else if (k == 1 && expr.size() == 1 && (d & 3) != 3) expr.push_back(d & 3);
                else if (k == 0 && expr.size() == 2) expr.push_back(d);
                else if (k == 2 && expr.size() == 3) computing = 1;
                else if (CH && k == 1 && expr.size() == 0 && chain && (d & 3) != 3) begin
                    expr.push_back(m_res & 15);
                    expr.push_back(d & 3);
                end else begin
                    m_err = 1; expr.delete(); chain = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input int k, input int d, input bit ordy);
        rst = r; in_valid = v; in_kind = k[1:0]; in_data = d[3:0]; out_ready = ordy;
        model(r, v, k, d, ordy);
        @(posedge clk);
        #1;
        chk("in_ready", 16'(in_ready), 16'(!(computing || holding)));
        chk("busy", 16'(busy), 16'(computing || holding));
        chk("out_valid", 16'(out_valid), 16'(holding));
        chk("err", 16'(err), 16'(m_err));
        chk("out_res", 16'(out_res), 16'(m_res));
        chk("out_op", 16'(out_op), 16'(m_op));
    endtask

    task automatic tok(input int k, input int d);
        step(0, 1, k, d, 1);
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, ordy);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_kind = 0; in_data = 0; out_ready = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_res", 16'(out_res), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        tok(0, 9); tok(1, 0); tok(0, 8); tok(2, 0);
        chk("exec_valid", 16'(out_valid), 16'd0);
        chk("exec_busy", 16'(busy), 16'd1);
        idle(1);
        chk("add_valid", 16'(out_valid), 16'd1);
        chk("add_res", 16'(out_res), 16'h11);
        chk("add_op", 16'(out_op), 16'd0);
        idle(1);
        chk("add_done", 16'(out_valid), 16'd0);
        tok(0, 3); tok(1, 1); tok(0, 5); tok(2, 0); idle(1);
        chk("sub_res", 16'(out_res), 16'h1E);
        idle(1);
        tok(0, 15); tok(1, 2); tok(0, 15); tok(2, 0); idle(0);
        chk("mul_res", 16'(out_res), 16'hE1);
        for (int i = 0; i < 5; i++) begin
            idle(0);
            chk("stall_res", 16'(out_res), 16'hE1);
            chk("stall_ready", 16'(in_ready), 16'd0);
        end
        idle(1);
        chk("stall_done", 16'(out_valid), 16'd0);
        idle(1);
        chk("stall_once", 16'(out_valid), 16'd0);
        tok(0, 4); tok(0, 5);
        chk("dig_err", 16'(err), 16'd1);
        idle(0);
        chk("dig_err_pulse", 16'(err), 16'd0);
        tok(0, 4); tok(3, 0);
        chk("clr_noerr", 16'(err), 16'd0);
        tok(0, 1); tok(1, 0); tok(0, 1); tok(2, 0); idle(1);
        chk("after_clr_res", 16'(out_res), 16'h02);
        idle(1);
        tok(0, 6); tok(1, 2); tok(0, 7); tok(2, 0); idle(0);
        chk("pre_rst_valid", 16'(out_valid), 16'd1);
        step(1, 0, 0, 0, 0);
        chk("rst_out_valid2", 16'(out_valid), 16'd0);
        chk("rst_in_ready2", 16'(in_ready), 16'd1);
        chk("rst_out_res2", 16'(out_res), 16'd0);
        tok(0, 2); tok(1, 2); tok(0, 3); tok(2, 0); idle(1);
        chk("chain_base", 16'(out_res), 16'h06);
        idle(1);
        tok(1, 0);
`ifdef CALC_CHAIN_EN
        tok(0, 7); tok(2, 0); idle(1);
        chk("chain_res", 16'(out_res), 16'h0D);
        idle(1);
`else
        chk("chain_err", 16'(err), 16'd1);
`endif
        for (int i = 0; i < 3000; i++) begin
            int want, k, d;
            want = expr.size() == 0 ? 0 : expr.size() == 1 ? 1 : expr.size() == 2 ? 0 : 2;
            k = $urandom_range(3) != 0 ? want : int'($urandom_range(3));
            d = k == 1 ? int'($urandom_range(3)) : int'($urandom_range(15));
            step($urandom_range(63) == 0, $urandom_range(3) != 0, k, d, 1'($urandom_range(1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
